// File: rtl/sbasu3_spi_pkg.sv
// Shared SPI definitions used by both the master and the slave side.
package sbasu3_spi_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } spi_state_e;

endpackage

// File: rtl/sbasu3_spi_tick.sv
// Half-period timer: auto-reloading down-counter that pulses tick for one
// cycle when it reaches zero while enabled.
module sbasu3_spi_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_reg;

  assign tick = en && (count_reg == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load || tick) begin
      count_reg <= RELOAD;
    end else if (en) begin
      count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/sbasu3_spi_master.sv
// SPI mode-0 master: one full-duplex DATA_W-bit exchange per accepted start,
// MSB first, with a CLK_DIV-cycle setup before and idle gap after each byte.
module sbasu3_spi_master #(
  parameter int CLK_DIV = sbasu3_spi_pkg::DEF_CLK_DIV,
  parameter int DATA_W  = sbasu3_spi_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              ss,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  import sbasu3_spi_pkg::*;

  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  spi_state_e        state_reg, state_next;
  logic [DATA_W-1:0] tx_shift_reg, tx_shift_next;
  logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
  logic [DATA_W-1:0] rx_data_reg, rx_data_next;
  logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic              ss_reg, ss_next;
  logic              sclk_reg, sclk_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              tick_load, tick_en, tick;

  sbasu3_spi_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .load(tick_load),
    .en  (tick_en),
    .tick(tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      bit_cnt_reg  <= '0;
      ss_reg       <= 1'b1;
      sclk_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      bit_cnt_reg  <= bit_cnt_next;
      ss_reg       <= ss_next;
      sclk_reg     <= sclk_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    bit_cnt_next  = bit_cnt_reg;
    ss_next       = ss_reg;
    sclk_next     = sclk_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    tick_load     = 1'b0;
    tick_en       = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (start) begin
          tx_shift_next = tx_data;
          bit_cnt_next  = '0;
          ss_next       = 1'b0;
          busy_next     = 1'b1;
          tick_load     = 1'b1;
          state_next    = SETUP;
        end
      end

      SETUP: begin
        if (tick) begin
          sclk_next     = 1'b1;
          rx_shift_next = {rx_shift_reg[DATA_W-2:0], miso};
          state_next    = SHIFT;
        end
      end

      SHIFT: begin
        if (tick) begin
          if (sclk_reg) begin
            sclk_next = 1'b0;
            // mosi is the shifter MSB; the last falling edge leaves it alone
            if (bit_cnt_reg != LAST_BIT) begin
              tx_shift_next = {tx_shift_reg[DATA_W-2:0], 1'b0};
            end
          end else if (bit_cnt_reg == LAST_BIT) begin
            ss_next       = 1'b1;
            tx_shift_next = '0;
            rx_data_next  = rx_shift_reg;
            done_next     = 1'b1;
            state_next    = GAP;
          end else begin
            sclk_next     = 1'b1;
            rx_shift_next = {rx_shift_reg[DATA_W-2:0], miso};
            bit_cnt_next  = bit_cnt_reg + BW'(1);
          end
        end
      end

      GAP: begin
        if (tick) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign rx_data = rx_data_reg;
  assign ss      = ss_reg;
  assign sclk    = sclk_reg;
  assign mosi    = tx_shift_reg[DATA_W-1];

endmodule

// File: doc/sbasu3_spi_master.md
# sbasu3_spi_master

SPI mode-0 master that drives `ss`, `sclk` and `mosi` and samples `miso`, exchanging one byte per request. It is the initiator counterpart of the SPI slave inside `sbasu3_top`. It serves as the on-chip test initiator and as the host-side engine in system builds. A one-cycle `start` handshake launches a full-duplex 8-bit transfer; `done` pulses when `rx_data` is valid.

## Interface
- `CLK_DIV`, 4, system clocks per `sclk` half-period; legal range is 2..255.
- `DATA_W`, 8, bits per transfer, shifted MSB first.
- `clk`  in  1  system clock; every flop is rising-edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `start`  in  1  transfer request; accepted only in IDLE.
- `tx_data`  in  DATA_W  byte to send; captured on the accepting edge.
- `busy`  out  1  high from the accepting edge until the transfer is fully complete.
- `done`  out  1  one-cycle pulse; `rx_data` is valid from this cycle.
- `rx_data`  out  DATA_W  last received byte; held until the next `done`.
- `ss`  out  1  slave select, active-low.
- `sclk`  out  1  SPI clock; idles low (CPOL=0).
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in; already synchronous to `clk`, no synchronizer.

## Operation
- Reset values: `ss`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0. State is IDLE. Half-period counter is 0.
- FSM states: IDLE, SETUP, SHIFT, GAP.
- IDLE, `start`=1 at an edge:
  - load the shift register from `tx_data`;
  - drive `ss`=0, `mosi`=`tx_data[DATA_W-1]`, `busy`=1;
  - go to SETUP.
- SETUP lasts CLK_DIV cycles with `sclk`=0, then goes to SHIFT.
- SHIFT runs DATA_W bit periods. Each bit period is a high phase of CLK_DIV cycles followed by a low phase of CLK_DIV cycles.
  - Rising `sclk` (entering a high phase): shift `miso` into the LSB of the receive register.
  - Falling `sclk` (entering a low phase): present the next tx bit on `mosi`. The final falling edge does not change `mosi`.
  - The low phase of the last bit is the ss hold time.
  - At the end of the last low phase: `ss`=1, `mosi`=0, `rx_data` updated, `done`=1 for one cycle, go to GAP.
- GAP lasts CLK_DIV cycles with `ss`=1 and `busy`=1, then goes to IDLE with `busy`=0.
- `start` while `busy`=1 is ignored; it is neither queued nor an error.
- `tx_data` changes after the accepting edge have no effect on the transfer in progress.
- `rst` asserted mid-transfer: all outputs return to their reset values immediately (asynchronously); the partial byte is discarded and `done` does not pulse.
- A `miso` value that is X or Z is not checked; it is shifted in as-is.

## Timing
- Let N be the accepting edge. Outputs are registered, so `ss`=0 and `busy`=1 are visible from cycle N+1.
- First `sclk` rise is at N+1+CLK_DIV. Rise k (k=0..DATA_W-1) is at N+1+CLK_DIV·(1+2k).
- `miso` is sampled on the same clk edge that drives `sclk` high, so it uses the value present before the rise.
- `done`=1, `ss`=1 and new `rx_data` appear together at cycle N+1+CLK_DIV·(1+2·DATA_W), i.e. N+1+17·CLK_DIV for the defaults.
- `busy` falls CLK_DIV cycles after `done`.
- Earliest next accept is the edge at which `busy` is first seen 0. The minimum `ss`-high gap is CLK_DIV+1 cycles.
- Counter width is $clog2(CLK_DIV). Bit counter width is $clog2(DATA_W)+1.

## Structure
- Shared package `sbasu3_spi_pkg` holds the state enum {IDLE, SETUP, SHIFT, GAP} and the defaults for DATA_W and CLK_DIV. The slave side shares the same package.
- One sub-module, `sbasu3_spi_tick`: a half-period down-counter with `load`/`en` inputs and a one-cycle `tick` output at terminal count. The FSM and both shift registers stay in the top module.

## Test plan
- CLK_DIV=4, `miso` looped back to `mosi`, `tx_data`=0xA5: `rx_data`=0xA5 at `done`; exactly 8 `sclk` rises; `done` at N+69.
- Bench slave model returns 0x3C on `miso` while `tx_data`=0xF0: `mosi` bit sequence 1,1,1,1,0,0,0,0 at the rises; `rx_data`=0x3C.
- `start` pulsed again at N+10 and N+40 during a transfer: no second transfer starts; `ss` stays low and continuous; exactly one `done`.
- `rst` driven low at N+30: `ss`=1, `sclk`=0 and `busy`=0 immediately; no `done`; the next `start` gives a clean transfer, checked with 0x81.
- Back-to-back with `start` held high, 0x12 then 0x34: two `done` pulses 18·CLK_DIV+1 cycles apart; `ss` high for CLK_DIV+1 cycles between transfers.
- CLK_DIV=2, `tx_data`=0x00, `miso`=1: `rx_data`=0xFF; `sclk` period is 4 cycles.
